// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder end of the memory-controller bus. Owns a word-addressed 32-bit
//   data RAM, accepts byte-masked writes and returns read data after a fixed
//   READ_LATENCY. Requests that are misaligned or outside the window
//   [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) are rejected and flagged.
//
//   Optional feature macro: MEM_RESP_STATS_EN adds read/write completion
//   counters (ports read_count / write_count).
//
//   Ports:
//     clk           rising-edge clock for all state
//     rst           synchronous, active-high reset (RAM contents untouched)
//     address       byte address of the request
//     read_enable   read request this cycle
//     write_enable  write request this cycle
//     write_data    write data, byte lane i = bits [8i+7:8i]
//     byte_enables  per-lane write mask
//     read_data     returned read data, holds between responses
//     read_valid    one-cycle pulse marking new read_data
//     access_error  one-cycle pulse for a rejected request
//     read_count    completed legal reads  (MEM_RESP_STATS_EN only)
//     write_count   completed legal writes (MEM_RESP_STATS_EN only)

module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_enables,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        access_error
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [31:0] read_count,
  output logic [31:0] write_count
`endif
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // 33 bits so a window ending exactly at 2^32 still compares correctly.
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]   offset;
  logic          legal;
  logic [AW-1:0] idx;

  always_comb begin
    offset = address - BASE_ADDR;
    legal  = (address[1:0] == 2'b00)
          && ({1'b0, address} >= {1'b0, BASE_ADDR})
          && ({1'b0, address} <  END_ADDR);
    idx    = AW'(offset >> 2);
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (!rst && write_enable && legal) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_enables[b]) begin
          mem[idx][8*b +: 8] <= write_data[8*b +: 8];
        end
      end
    end
  end

  // Read pipeline. Stage 0 captures the RAM word at the sampling edge, which
  // gives read-before-write when a write lands on the same edge. Data words
  // only advance behind a valid entry, so the last stage doubles as the
  // "hold last returned value" register for read_data.
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [READ_LATENCY-1:0] pipe_err;
  logic [31:0]             pipe_data [READ_LATENCY];
  logic                    wr_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
      wr_err <= 1'b0;
    end else begin
      pipe_valid[0] <= read_enable;
      pipe_err[0]   <= read_enable && !legal;
      if (read_enable) begin
        pipe_data[0] <= legal ? mem[idx] : '0;
      end
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        if (pipe_valid[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
        end
      end
      // A combined illegal read+write reports once, via the read path.
      wr_err <= write_enable && !read_enable && !legal;
    end
  end

  assign read_valid   = pipe_valid[READ_LATENCY-1];
  assign read_data    = pipe_data[READ_LATENCY-1];
  assign access_error = pipe_err[READ_LATENCY-1] | wr_err;

`ifdef MEM_RESP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      read_count  <= '0;
      write_count <= '0;
    end else begin
      if (pipe_valid[READ_LATENCY-1] && !pipe_err[READ_LATENCY-1]) begin
        read_count <= read_count + 32'd1;
      end
      if (write_enable && legal) begin
        write_count <= write_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Directed bench for data_mem_responder. Two instances share one request
//   bus: u1 with READ_LATENCY=1 and u3 with READ_LATENCY=3, so every scenario
//   checks both latencies. Inputs change on the falling edge and outputs are
//   sampled on the falling edge.

module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        rd;
  logic        wr;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic [31:0] rdata1, rdata3;
  logic        rv1, rv3, err1, err3;
`ifdef MEM_RESP_STATS_EN
  logic [31:0] rcnt1, wcnt1, rcnt3, wcnt3;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .READ_LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .address(addr), .read_enable(rd), .write_enable(wr),
    .write_data(wdata), .byte_enables(be), .read_data(rdata1), .read_valid(rv1),
    .access_error(err1)
`ifdef MEM_RESP_STATS_EN
    , .read_count(rcnt1), .write_count(wcnt1)
`endif
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .READ_LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .address(addr), .read_enable(rd), .write_enable(wr),
    .write_data(wdata), .byte_enables(be), .read_data(rdata3), .read_valid(rv3),
    .access_error(err3)
`ifdef MEM_RESP_STATS_EN
    , .read_count(rcnt3), .write_count(wcnt3)
`endif
  );

  // Present one request for a single clock, then return the bus to idle.
  // On return the latency-1 response is visible.
  task automatic issue(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    rd = r; wr = w; addr = a; wdata = d; be = b;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1: got %h expected %h", rdata1, 32'h0); end
    checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL reset_rv1: got %b expected %b", rv1, 1'b0); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_err1: got %b expected %b", err1, 1'b0); end
    checks++; if (rdata3 !== 32'h0) begin errors++; $display("FAIL reset_rdata3: got %h expected %h", rdata3, 32'h0); end
    checks++; if (rv3 !== 1'b0) begin errors++; $display("FAIL reset_rv3: got %b expected %b", rv3, 1'b0); end
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL reset_err3: got %b expected %b", err3, 1'b0); end
`ifdef MEM_RESP_STATS_EN
    checks++; if (rcnt1 !== 32'h0) begin errors++; $display("FAIL reset_rcnt1: got %0d expected 0", rcnt1); end
    checks++; if (wcnt3 !== 32'h0) begin errors++; $display("FAIL reset_wcnt3: got %0d expected 0", wcnt3); end
`endif
  endtask

  task automatic test_full_write_read;
    issue(1'b0, 1'b1, 32'h10, 32'hCAFE_F00D, 4'hF);
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL fw_err1: got %b expected %b", err1, 1'b0); end
    checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL fw_rv1_on_write: got %b expected %b", rv1, 1'b0); end
    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    checks++; if (rv1 !== 1'b1) begin errors++; $display("FAIL fw_rv1: got %b expected %b", rv1, 1'b1); end
    checks++; if (rdata1 !== 32'hCAFE_F00D) begin errors++; $display("FAIL fw_rdata1: got %h expected %h", rdata1, 32'hCAFE_F00D); end
    checks++; if (rv3 !== 1'b0) begin errors++; $display("FAIL fw_rv3_early: got %b expected %b", rv3, 1'b0); end
    idle(1);
    checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL fw_rv1_pulse: got %b expected %b", rv1, 1'b0); end
    checks++; if (rdata1 !== 32'hCAFE_F00D) begin errors++; $display("FAIL fw_rdata1_hold: got %h expected %h", rdata1, 32'hCAFE_F00D); end
    checks++; if (rv3 !== 1'b0) begin errors++; $display("FAIL fw_rv3_early2: got %b expected %b", rv3, 1'b0); end
    idle(1);
    checks++; if (rv3 !== 1'b1) begin errors++; $display("FAIL fw_rv3: got %b expected %b", rv3, 1'b1); end
    checks++; if (rdata3 !== 32'hCAFE_F00D) begin errors++; $display("FAIL fw_rdata3: got %h expected %h", rdata3, 32'hCAFE_F00D); end
    idle(1);
    checks++; if (rv3 !== 1'b0) begin errors++; $display("FAIL fw_rv3_pulse: got %b expected %b", rv3, 1'b0); end
  endtask

  task automatic test_partial_write;
    issue(1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
    issue(1'b0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101);
    issue(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    checks++; if (rdata1 !== 32'h11BB_33DD) begin errors++; $display("FAIL partial_rdata1: got %h expected %h", rdata1, 32'h11BB_33DD); end
    idle(2);
    checks++; if (rdata3 !== 32'h11BB_33DD) begin errors++; $display("FAIL partial_rdata3: got %h expected %h", rdata3, 32'h11BB_33DD); end
  endtask

  task automatic test_read_write_same;
    issue(1'b0, 1'b1, 32'h30, 32'h0, 4'hF);
    issue(1'b1, 1'b1, 32'h30, 32'h5, 4'hF);
    checks++; if (rv1 !== 1'b1) begin errors++; $display("FAIL rw_rv1: got %b expected %b", rv1, 1'b1); end
    checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL rw_old_rdata1: got %h expected %h", rdata1, 32'h0); end
    idle(2);
    checks++; if (rdata3 !== 32'h0) begin errors++; $display("FAIL rw_old_rdata3: got %h expected %h", rdata3, 32'h0); end
    issue(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
    checks++; if (rdata1 !== 32'h5) begin errors++; $display("FAIL rw_new_rdata1: got %h expected %h", rdata1, 32'h5); end
    idle(2);
    checks++; if (rdata3 !== 32'h5) begin errors++; $display("FAIL rw_new_rdata3: got %h expected %h", rdata3, 32'h5); end
  endtask

  task automatic test_back_to_back;
    issue(1'b0, 1'b1, 32'h0, 32'hA000_0000, 4'hF);
    issue(1'b0, 1'b1, 32'h4, 32'hA000_0004, 4'hF);
    issue(1'b0, 1'b1, 32'h8, 32'hA000_0008, 4'hF);
    rd = 1'b1; addr = 32'h0;
    @(negedge clk);
    checks++; if (rdata1 !== 32'hA000_0000 || rv1 !== 1'b1) begin errors++; $display("FAIL b2b_u1_0: got %h/%b expected %h/1", rdata1, rv1, 32'hA000_0000); end
    addr = 32'h4;
    @(negedge clk);
    checks++; if (rdata1 !== 32'hA000_0004 || rv1 !== 1'b1) begin errors++; $display("FAIL b2b_u1_1: got %h/%b expected %h/1", rdata1, rv1, 32'hA000_0004); end
    checks++; if (rv3 !== 1'b0) begin errors++; $display("FAIL b2b_u3_early: got %b expected %b", rv3, 1'b0); end
    addr = 32'h8;
    @(negedge clk);
    rd = 1'b0;
    checks++; if (rdata1 !== 32'hA000_0008 || rv1 !== 1'b1) begin errors++; $display("FAIL b2b_u1_2: got %h/%b expected %h/1", rdata1, rv1, 32'hA000_0008); end
    checks++; if (rdata3 !== 32'hA000_0000 || rv3 !== 1'b1) begin errors++; $display("FAIL b2b_u3_0: got %h/%b expected %h/1", rdata3, rv3, 32'hA000_0000); end
    @(negedge clk);
    checks++; if (rdata3 !== 32'hA000_0004 || rv3 !== 1'b1) begin errors++; $display("FAIL b2b_u3_1: got %h/%b expected %h/1", rdata3, rv3, 32'hA000_0004); end
    @(negedge clk);
    checks++; if (rdata3 !== 32'hA000_0008 || rv3 !== 1'b1) begin errors++; $display("FAIL b2b_u3_2: got %h/%b expected %h/1", rdata3, rv3, 32'hA000_0008); end
    @(negedge clk);
    checks++; if (rv3 !== 1'b0) begin errors++; $display("FAIL b2b_u3_end: got %b expected %b", rv3, 1'b0); end
  endtask

  task automatic test_illegal;
    // Misaligned read.
    issue(1'b1, 1'b0, 32'h2, 32'h0, 4'h0);
    checks++; if (rv1 !== 1'b1 || err1 !== 1'b1 || rdata1 !== 32'h0) begin errors++; $display("FAIL mis_rd_u1: got v=%b e=%b d=%h expected v=1 e=1 d=0", rv1, err1, rdata1); end
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL mis_rd_err3_early: got %b expected %b", err3, 1'b0); end
    idle(2);
    checks++; if (rv3 !== 1'b1 || err3 !== 1'b1 || rdata3 !== 32'h0) begin errors++; $display("FAIL mis_rd_u3: got v=%b e=%b d=%h expected v=1 e=1 d=0", rv3, err3, rdata3); end
    idle(1);
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL mis_rd_err3_pulse: got %b expected %b", err3, 1'b0); end
    // Write one past the last word: flagged after one cycle on both, RAM untouched.
    issue(1'b0, 1'b1, 32'h1000, 32'hDEAD_BEEF, 4'hF);
    checks++; if (err1 !== 1'b1 || err3 !== 1'b1) begin errors++; $display("FAIL oob_wr_err: got %b/%b expected 1/1", err1, err3); end
    checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL oob_wr_rv1: got %b expected %b", rv1, 1'b0); end
    idle(1);
    checks++; if (err1 !== 1'b0 || err3 !== 1'b0) begin errors++; $display("FAIL oob_wr_pulse: got %b/%b expected 0/0", err1, err3); end
    issue(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    checks++; if (rdata1 !== 32'hA000_0000 || err1 !== 1'b0) begin errors++; $display("FAIL oob_wr_ram: got %h e=%b expected %h e=0", rdata1, err1, 32'hA000_0000); end
    idle(3);
    // Last legal word.
    issue(1'b0, 1'b1, 32'hFFC, 32'h0BAD_F00D, 4'hF);
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL last_wr_err1: got %b expected %b", err1, 1'b0); end
    issue(1'b1, 1'b0, 32'hFFC, 32'h0, 4'h0);
    checks++; if (rdata1 !== 32'h0BAD_F00D || err1 !== 1'b0) begin errors++; $display("FAIL last_rd: got %h e=%b expected %h e=0", rdata1, err1, 32'h0BAD_F00D); end
    idle(3);
    // Illegal combined read+write: one pulse, aligned to the read response.
    issue(1'b1, 1'b1, 32'h1002, 32'h1, 4'hF);
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL rw_ill_err3_c1: got %b expected %b", err3, 1'b0); end
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL rw_ill_err1: got %b expected %b", err1, 1'b1); end
    idle(1);
    checks++; if (err1 !== 1'b0 || err3 !== 1'b0) begin errors++; $display("FAIL rw_ill_c2: got %b/%b expected 0/0", err1, err3); end
    idle(1);
    checks++; if (err3 !== 1'b1 || rv3 !== 1'b1) begin errors++; $display("FAIL rw_ill_err3_c3: got e=%b v=%b expected e=1 v=1", err3, rv3); end
    idle(1);
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL rw_ill_err3_pulse: got %b expected %b", err3, 1'b0); end
  endtask

  task automatic test_reset_midop;
    rd = 1'b1; addr = 32'h10;
    @(negedge clk);
    @(negedge clk);
    rd = 1'b0; rst = 1'b1;
    wr = 1'b1; addr = 32'h10; wdata = 32'h1234_5678; be = 4'hF;
    @(negedge clk);
    rst = 1'b0; wr = 1'b0;
    checks++; if (rv1 !== 1'b0 || rv3 !== 1'b0) begin errors++; $display("FAIL midrst_rv: got %b/%b expected 0/0", rv1, rv3); end
    checks++; if (rdata1 !== 32'h0 || rdata3 !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h/%h expected 0/0", rdata1, rdata3); end
    checks++; if (err1 !== 1'b0 || err3 !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b/%b expected 0/0", err1, err3); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (rv1 !== 1'b0 || rv3 !== 1'b0) begin errors++; $display("FAIL midrst_flushed[%0d]: got %b/%b expected 0/0", i, rv1, rv3); end
    end
    issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    checks++; if (rdata1 !== 32'hCAFE_F00D) begin errors++; $display("FAIL midrst_wr_ignored1: got %h expected %h", rdata1, 32'hCAFE_F00D); end
    idle(2);
    checks++; if (rdata3 !== 32'hCAFE_F00D) begin errors++; $display("FAIL midrst_wr_ignored3: got %h expected %h", rdata3, 32'hCAFE_F00D); end
    idle(2);
  endtask

`ifdef MEM_RESP_STATS_EN
  task automatic test_counters;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 1'b1, 32'h40, 32'h1, 4'hF);
    issue(1'b0, 1'b1, 32'h44, 32'h2, 4'hF);
    issue(1'b0, 1'b1, 32'h48, 32'h3, 4'hF);
    issue(1'b0, 1'b1, 32'h4C, 32'h4, 4'hF);
    issue(1'b0, 1'b1, 32'h40, 32'h9, 4'h0);
    issue(1'b0, 1'b1, 32'h1000, 32'h7, 4'hF);
    issue(1'b1, 1'b0, 32'h41, 32'h0, 4'h0);
    issue(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    issue(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    issue(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    checks++; if (rdata1 !== 32'h1) begin errors++; $display("FAIL cnt_be0_noop: got %h expected %h", rdata1, 32'h1); end
    idle(5);
    checks++; if (wcnt1 !== 32'd5 || wcnt3 !== 32'd5) begin errors++; $display("FAIL cnt_writes: got %0d/%0d expected 5/5", wcnt1, wcnt3); end
    checks++; if (rcnt1 !== 32'd3 || rcnt3 !== 32'd3) begin errors++; $display("FAIL cnt_reads: got %0d/%0d expected 3/3", rcnt1, rcnt3); end
  endtask
`endif

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; be = '0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_full_write_read;
    test_partial_write;
    test_read_write_same;
    test_back_to_back;
    test_illegal;
    test_reset_midop;
`ifdef MEM_RESP_STATS_EN
    test_counters;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
